// File: rtl/muacm_arb_pkg.sv
// Shared types and defaults for the muacm IN-pipe arbiter.
// Optional one-cycle flush state is enabled with MUACM_ARB_FLUSH_EN.
package muacm_arb_pkg;

  localparam int unsigned ARB_MAX_BURST = 64;
  localparam int unsigned ARB_IDLE_TO   = 255;

`ifdef MUACM_ARB_FLUSH_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } arb_state_e;
`endif

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/muacm_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, one-hot.
module muacm_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  int unsigned cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(start) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any && j == cand && req[j]) begin
          any      = 1'b1;
          pick[j]  = 1'b1;
          pick_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/muacm_in_arb.sv
// Round-robin arbiter sharing the muacm USB IN pipe between NUM_REQ byte streams.
// Define MUACM_ARB_FLUSH_EN to add a one-cycle flush request after each packet.
module muacm_in_arb
  import muacm_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = ARB_MAX_BURST,
  parameter int unsigned IDLE_TO   = ARB_IDLE_TO
) (
  input  logic                 clk_usb,
  input  logic                 rst_usb,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_flush_now,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TO + 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               busy_q;
  logic               flush_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               in_grant;
  logic               own_valid;
  logic               own_last;
  logic               burst_end;
  logic               beat;
  logic               rel_last;
  logic               rel_timeout;

  muacm_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req_valid),
    .start    (rr_ptr_q),
    .pick     (pick_onehot),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Owner-side mux: the IN stream passes through combinationally while granted.
  always_comb begin
    in_grant  = (state_q == ST_GRANT);
    own_valid = 1'b0;
    own_last  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (in_grant && owner_q == IDX_W'(i)) begin
        own_valid    = req_valid[i];
        own_last     = req_last[i];
        out_data     = req_data[8*i +: 8];
        req_ready[i] = out_ready;
      end
    end
    burst_end   = (beat_q == BEAT_W'(MAX_BURST - 1));
    out_valid   = own_valid;
    out_last    = in_grant && (own_last || burst_end);
    beat        = out_valid && out_ready;
    rel_last    = beat && out_last;
    rel_timeout = in_grant && !own_valid && (idle_q == IDLE_W'(IDLE_TO - 1));
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign out_flush_now = flush_q;

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      idle_q   <= '0;
      busy_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            beat_q  <= '0;
            idle_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (beat) beat_q <= beat_q + BEAT_W'(1);
          idle_q <= own_valid ? '0 : idle_q + IDLE_W'(1);
          if (rel_last || rel_timeout) begin
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(rr_next(32'(owner_q), NUM_REQ));
            beat_q   <= '0;
            idle_q   <= '0;
`ifdef MUACM_ARB_FLUSH_EN
            if (rel_last) begin
              state_q <= ST_FLUSH;
              flush_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
`ifdef MUACM_ARB_FLUSH_EN
        ST_FLUSH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muacm_in_arb.sv
// Directed scoreboard bench for muacm_in_arb (default parameters, NUM_REQ=2).
module tb_muacm_in_arb;

  localparam int unsigned N = 2;
`ifdef MUACM_ARB_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic           clk_usb = 1'b0;
  logic           rst_usb;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [7:0]     out_data;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic           out_flush_now;
  logic [N-1:0]   grant;
  logic           busy;

  typedef struct packed {
    logic [7:0]   data;
    logic         last;
    logic [N-1:0] grant;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  int         checks = 0;
  int         errors = 0;
  int         beats  = 0;
  logic       toggle_ready = 1'b0;
  logic       prev_last = 1'b0;

  always #5 clk_usb = ~clk_usb;

  muacm_in_arb dut (
    .clk_usb       (clk_usb),
    .rst_usb       (rst_usb),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flush_now (out_flush_now),
    .grant         (grant),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the head of each source queue to the DUT.
  task automatic drive();
    logic [8:0] h0;
    logic [8:0] h1;
    h0 = (src0.size() != 0) ? src0[0] : 9'h0;
    h1 = (src1.size() != 0) ? src1[0] : 9'h0;
    req_valid = {src1.size() != 0, src0.size() != 0};
    req_data  = {h1[7:0], h0[7:0]};
    req_last  = {h1[8], h0[8]};
    out_ready = toggle_ready ? ~out_ready : 1'b1;
  endtask

  task automatic step();
    logic acc0;
    logic acc1;
    @(negedge clk_usb);
    acc0 = req_valid[0] && req_ready[0];
    acc1 = req_valid[1] && req_ready[1];
    @(posedge clk_usb);
    #1;
    if (acc0) void'(src0.pop_front());
    if (acc1) void'(src1.pop_front());
    drive();
  endtask

  task automatic pkt(input int req, input logic [7:0] base, input int len,
                     input bit has_last, input logic [N-1:0] g);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      logic       l;
      b = base + 8'(i);
      l = has_last && (i == len - 1);
      if (req == 0) src0.push_back({l, b});
      else          src1.push_back({l, b});
      exp_q.push_back('{data: b, last: l, grant: g});
    end
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0) && n < max) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_grant"},     32'(grant),         32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_out_valid"}, 32'(out_valid),     32'd0);
    check({tag, "_out_last"},  32'(out_last),      32'd0);
    check({tag, "_req_ready"}, 32'(req_ready),     32'd0);
    check({tag, "_flush"},     32'(out_flush_now), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_usb = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    toggle_ready = 1'b0;
    drive();
    repeat (2) @(posedge clk_usb);
    #1;
    reset_check(tag);
    rst_usb = 1'b0;
  endtask

  // Output monitor: every beat is popped against the scoreboard, flush checked each cycle.
  initial begin
    forever begin
      @(negedge clk_usb);
      if (rst_usb) begin
        prev_last = 1'b0;
      end else begin
        check("flush_now", 32'(out_flush_now), 32'(FLUSH_EN && prev_last));
        prev_last = out_valid && out_ready && out_last;
        if (out_valid && out_ready) begin
          beats++;
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_last", 32'(out_last), 32'(e.last));
            check("grant",    32'(grant),    32'(e.grant));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_usb   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    do_reset("por");

    // Single 5-byte packet from req0; one idle cycle before the grant.
    pkt(0, 8'h10, 5, 1'b1, 2'b01);
    drive();
    @(negedge clk_usb);
    check("arb_idle_grant", 32'(grant), 32'd0);
    check("arb_idle_ready", 32'(req_ready), 32'd0);
    check("arb_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk_usb);
    #1;
    run(50);
    step();
    step();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_grant_after", 32'(grant), 32'd0);

    // Two requesters from reset: req0, req1, req0.
    do_reset("t2");
    pkt(0, 8'h20, 3, 1'b1, 2'b01);
    pkt(1, 8'h30, 3, 1'b1, 2'b10);
    pkt(0, 8'h40, 3, 1'b1, 2'b01);
    drive();
    run(200);

    // 70-byte stream from req1 is split at MAX_BURST.
    do_reset("t3");
    for (int i = 0; i < 70; i++) begin
      src1.push_back({1'b0, 8'(i)});
      exp_q.push_back('{data: 8'(i), last: (i == 63), grant: 2'b10});
    end
    drive();
    n = 0;
    while (src1.size() > 6 && n < 200) begin
      step();
      n++;
    end
    check("t3_split_left", 32'(src1.size()), 32'd6);
    check("t3_released", 32'(grant), 32'd0);
    check("t3_flush_state", 32'(out_flush_now), 32'(FLUSH_EN));
    run(200);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("t3_tail_timeout", 32'(busy), 32'd0);

    // Two bytes then valid drops: release after IDLE_TO idle cycles.
    do_reset("t4");
    pkt(0, 8'h50, 2, 1'b0, 2'b01);
    drive();
    run(50);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_usb);
      if (grant !== 2'b01) break;
      n++;
    end
    check("t4_idle_cycles", 32'(n), 32'd255);
    check("t4_busy", 32'(busy), 32'd0);
    @(posedge clk_usb);
    #1;

    // Reset mid-packet with toggling out_ready; pointer must restart at req0.
    do_reset("t6");
    pkt(0, 8'h60, 1, 1'b1, 2'b01);
    drive();
    run(50);
    step();
    step();
    step();
    toggle_ready = 1'b1;
    pkt(0, 8'h70, 8, 1'b1, 2'b01);
    base = beats;
    drive();
    n = 0;
    while (beats < base + 3 && n < 100) begin
      step();
      n++;
    end
    check("t6_beats_before_reset", 32'(beats - base), 32'd3);
    #2;
    rst_usb = 1'b1;
    #1;
    reset_check("t6_mid");
    src0.delete();
    src1.delete();
    exp_q.delete();
    toggle_ready = 1'b0;
    drive();
    @(posedge clk_usb);
    #1;
    rst_usb = 1'b0;
    pkt(0, 8'h80, 1, 1'b1, 2'b01);
    pkt(1, 8'h90, 1, 1'b1, 2'b10);
    drive();
    run(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
